// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared encodings and frame constants for the USB transmit path
package usb_pkg;

    typedef enum logic [1:0] {
        PKT_NONE      = 2'b00,
        PKT_TOKEN     = 2'b01,
        PKT_HANDSHAKE = 2'b10,
        PKT_DATA      = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        CRC_NONE = 2'b00,
        CRC_5    = 2'b01,
        CRC_16   = 2'b10
    } crc_sel_e;

    // Written in line order: leftmost bit goes on the wire first.
    localparam logic [7:0] SYNC      = 8'b00000001;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    localparam int HDR_BITS       = 16;
    localparam int HANDSHAKE_BITS = 16;
    localparam int TOKEN_BITS     = 27;

    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Shift register must hold the longest of a token or a full data frame.
    function automatic int frame_width(input int max_bytes);
        int dw;
        dw = HDR_BITS + 8 * max_bytes;
        return (dw > TOKEN_BITS) ? dw : TOKEN_BITS;
    endfunction

endpackage

// File: rtl/usb_ser_piso.sv
// rtl/usb_ser_piso.sv - width-parametrised LSB-out parallel-in serial-out register
module usb_ser_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    output logic         dout
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (load) begin
            sr_d = load_data;
        end else if (shift_en) begin
            sr_d = {1'b0, sr_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[0];

endmodule

// File: rtl/usb_pkt_serializer.sv
// rtl/usb_pkt_serializer.sv - USB packet serializer FSM; USB_SER_ABORT_EN adds an abort input
module usb_pkt_serializer
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int LW             = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  pkt_type,
    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [7:0]                  pid,
    input  logic [10:0]                 token_body,
    input  logic [8*MAX_DATA_BYTES-1:0] data,
    input  logic [LW-1:0]               data_len,
`ifdef USB_SER_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        s_out,
    output logic                        s_valid,
    input  logic                        bit_ready,
    output logic [1:0]                  crc_sel,
    output logic                        crc_init,
    output logic                        crc_en,
    output logic                        eop,
    input  logic                        line_done,
    output logic                        pkt_sent
);

    localparam int FW = frame_width(MAX_DATA_BYTES);
    localparam int CW = $clog2(FW + 1);
    localparam int HW = $clog2(HDR_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_EOP_WAIT
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [HW-1:0]  hdr_q, hdr_d;
    crc_sel_e       sel_q, sel_d;
    logic           init_q, init_d;

    logic           abort_w;
    logic           piso_load;
    logic           piso_shift;
    logic           piso_clr;
    logic           piso_out;
    logic           sent_c;

    logic [LW-1:0]  len_c;
    logic [FW-1:0]  frame;
    logic [CW-1:0]  frame_len;
    crc_sel_e       frame_sel;

`ifdef USB_SER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Frame assembled so the shift register emits it LSB-first in line order.
    always_comb begin
        len_c      = (data_len > LW'(MAX_DATA_BYTES)) ? LW'(MAX_DATA_BYTES) : data_len;
        frame      = '0;
        frame[7:0] = bit_rev8(SYNC);
        frame[15:8] = pid;
        frame_len  = CW'(HANDSHAKE_BITS);
        frame_sel  = CRC_NONE;
        case (pkt_type)
            PKT_TOKEN: begin
                frame[26:16] = token_body;
                frame_len    = CW'(TOKEN_BITS);
                frame_sel    = CRC_5;
            end
            PKT_DATA: begin
                frame[16 +: 8*MAX_DATA_BYTES] = data;
                frame_len = CW'(HDR_BITS) + (CW'(len_c) << 3);
                frame_sel = CRC_16;
            end
            default: begin
                frame_len = CW'(HANDSHAKE_BITS);
                frame_sel = CRC_NONE;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        sel_d      = sel_q;
        init_d     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_clr   = 1'b0;
        sent_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid && (pkt_type != PKT_NONE)) begin
                    piso_load = 1'b1;
                    cnt_d     = frame_len;
                    hdr_d     = HW'(HDR_BITS);
                    sel_d     = frame_sel;
                    init_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort_w) begin
                    piso_clr = 1'b1;
                    cnt_d    = '0;
                    hdr_d    = '0;
                    sel_d    = CRC_NONE;
                    state_d  = S_IDLE;
                end else if (bit_ready) begin
                    piso_shift = 1'b1;
                    cnt_d      = cnt_q - CW'(1);
                    if (hdr_q != '0) begin
                        hdr_d = hdr_q - HW'(1);
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = S_EOP_WAIT;
                    end
                end
            end
            S_EOP_WAIT: begin
                // Abort wins over a simultaneous line_done so no completion is reported.
                if (abort_w) begin
                    piso_clr = 1'b1;
                    sel_d    = CRC_NONE;
                    state_d  = S_IDLE;
                end else if (line_done) begin
                    sent_c   = 1'b1;
                    piso_clr = 1'b1;
                    sel_d    = CRC_NONE;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            sel_q   <= CRC_NONE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            sel_q   <= sel_d;
            init_q  <= init_d;
        end
    end

    usb_ser_piso #(
        .W(FW)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .clr      (piso_clr),
        .load     (piso_load),
        .load_data(frame),
        .shift_en (piso_shift),
        .dout     (piso_out)
    );

    // Outputs are forced quiet while rst is held so the line sees no partial frame.
    assign pkt_ready = rst || (state_q == S_IDLE);
    assign s_valid   = !rst && (state_q == S_SHIFT);
    assign s_out     = s_valid && piso_out;
    assign crc_en    = s_valid && (hdr_q == '0);
    assign crc_sel   = rst ? 2'b00 : sel_q;
    assign crc_init  = !rst && init_q;
    assign eop       = !rst && (state_q == S_EOP_WAIT) && !abort_w;
    assign pkt_sent  = !rst && sent_c;

endmodule
